// File: rtl/fetch_unit_pkg.sv
// Shared fetch/decode control constants: next-PC select encodings, NOP word, reset vector.
package fetch_unit_pkg;
    typedef enum logic [1:0] {
        PC_REG    = 2'b00,
        PC_BRANCH = 2'b01,
        PC_SEQ    = 2'b10,
        PC_JUMP   = 2'b11
    } pcsel_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h4000_0000;
    localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: decode control in, instruction memory port, decode-facing outputs.
interface fetch_unit_if;
    logic        stall;
    logic [1:0]  pcsel;
    logic [31:0] branch_target;
    logic [31:0] reg_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_dout;
    logic [31:0] instr;
    logic [31:0] instr_old;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
    logic [31:0] instr_count;

    modport master (
        output stall, pcsel, branch_target, reg_target, imem_dout,
        input  imem_addr, instr, instr_old, pc, pc_plus4, valid, instr_count
    );

    modport slave (
        input  stall, pcsel, branch_target, reg_target, imem_dout,
        output imem_addr, instr, instr_old, pc, pc_plus4, valid, instr_count
    );
endinterface

// File: rtl/fetch_unit_next_pc_mux.sv
// Combinational next-PC select; result is always word aligned.
module next_pc_mux
    import fetch_unit_pkg::*;
(
    input  logic [1:0]  pcsel,
    input  logic [31:0] pc_plus4,
    input  logic [25:0] instr_index,
    input  logic [31:0] branch_target,
    input  logic [31:0] reg_target,
    output logic [31:0] npc
);
    logic [31:0] raw;

    always_comb begin
        raw = pc_plus4;
        case (pcsel_e'(pcsel))
            PC_SEQ:    raw = pc_plus4;
            PC_BRANCH: raw = branch_target;
            PC_JUMP:   raw = {pc_plus4[31:28], instr_index, 2'b00};
            PC_REG:    raw = reg_target;
            default:   raw = pc_plus4;
        endcase
    end

    assign npc = {raw[31:2], 2'b00};
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: drives a 1-cycle-latency imem, presents instr/pc to decode with no delay slot.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP      = NOP_WORD
) (
    input  logic       clk,
    input  logic       rst,
    fetch_unit_if.slave fif
);
    localparam logic [31:0] RESET_ADDR = {RESET_PC[31:2], 2'b00};

    logic [31:0] pc_q, instr_old_q, count_q;
    logic        valid_q;
    logic [31:0] npc, instr_w, pc_plus4_w;
    logic        advance;

    assign pc_plus4_w = pc_q + 32'd4;
    assign instr_w    = valid_q ? fif.imem_dout : NOP;
    assign advance    = valid_q & ~fif.stall & ~rst;

    next_pc_mux u_mux (
        .pcsel         (fif.pcsel),
        .pc_plus4      (pc_plus4_w),
        .instr_index   (instr_w[25:0]),
        .branch_target (fif.branch_target),
        .reg_target    (fif.reg_target),
        .npc           (npc)
    );

    // Presenting the redirect target in the same cycle is what removes the delay slot;
    // re-presenting pc_q on a hold makes the memory return the same word again.
    assign fif.imem_addr = rst ? RESET_ADDR : (advance ? npc : pc_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_ADDR;
            instr_old_q <= NOP;
            count_q     <= '0;
            valid_q     <= 1'b0;
        end else begin
            valid_q <= 1'b1;
            if (advance) begin
                pc_q        <= npc;
                instr_old_q <= instr_w;
                count_q     <= count_q + 32'd1;
            end
        end
    end

    assign fif.instr       = instr_w;
    assign fif.instr_old   = instr_old_q;
    assign fif.pc          = pc_q;
    assign fif.pc_plus4    = pc_plus4_w;
    assign fif.valid       = valid_q;
    assign fif.instr_count = count_q;
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h4000_0000, is the first fetch address after reset.
REQ-002 Parameter NOP, default 32'h0000_0000, is the instruction word driven while no valid instruction is present.
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port stall  input  1  hold the current instruction and PC for this cycle.
REQ-006 Port pcsel  input  2  next-PC select from decode: 2'b10 sequential, 2'b01 branch, 2'b11 jump, 2'b00 register.
REQ-007 Port branch_target  input  32  branch destination address.
REQ-008 Port reg_target  input  32  JR/JALR destination address (rs value).
REQ-009 Port imem_addr  output  32  byte address to synchronous instruction memory, with 1-cycle read latency.
REQ-010 Port imem_dout  input  32  instruction memory read data.
REQ-011 Port instr  output  32  current instruction, fed to decode as its current-instruction input.
REQ-012 Port instr_old  output  32  previous advanced instruction, fed to decode for forwarding.
REQ-013 Port pc  output  32  address of instr.
REQ-014 Port pc_plus4  output  32  pc + 4, used as the link value.
REQ-015 Port valid  output  1  instr is a real fetched instruction.
REQ-016 Port instr_count  output  32  count of advanced valid instructions, exposed as the memory-mapped counter.

Function
REQ-017 Register pc_q holds the address presented last cycle; imem_dout in the current cycle is mem[pc_q]; pc = pc_q.
REQ-018 instr = valid ? imem_dout : NOP.
REQ-019 An advance occurs when valid=1, stall=0 and rst=0.
REQ-020 Next PC on advance: 2'b10 -> pc_q+4; 2'b01 -> branch_target; 2'b11 -> {pc_plus4[31:28], instr[25:0], 2'b00}; 2'b00 -> reg_target.
REQ-021 imem_addr[1:0] is always 2'b00; target bits [1:0] are discarded.
REQ-022 The ISA has no delay slot: a redirect takes effect the next cycle with zero bubbles, and pc_q+4 is never fetched after a taken redirect.
REQ-023 On advance, imem_addr = next PC, pc_q <= next PC, instr_old <= instr, and instr_count <= instr_count+1.
REQ-024 On stall=1, imem_addr = pc_q, pc_q/instr_old/instr_count hold, pcsel is ignored, and instr is unchanged the next cycle.
REQ-025 While valid=0, imem_addr = pc_q, pcsel is ignored, and nothing advances.
REQ-026 pc_q + 4 wraps modulo 2^32; instr_count wraps from 32'hFFFF_FFFF to 0.
REQ-027 Priority: rst > stall > pcsel.
REQ-028 valid rises on the first clock edge with rst=0 after reset and stays high until the next reset.

Reset
REQ-029 While rst=1: imem_addr = RESET_PC; on the edge, pc_q <= RESET_PC, instr_old <= NOP, instr_count <= 0, valid <= 0.
REQ-030 Cycle 0 after deassertion: instr = NOP, valid = 0; cycle 1: instr = mem[RESET_PC], valid = 1.
REQ-031 rst asserted mid-operation discards any pending redirect or stall; the restart is identical to a cold reset.

Structure
REQ-032 The pcsel encodings, NOP and the default RESET_PC are shared constants in the common opcode/control header used by decode.
REQ-033 The next-PC computation is one combinational sub-module, next_pc_mux; all registers stay in fetch_unit.

Verification
REQ-034 Reset for 3 cycles, release, with mem[40000000]=24080001 -> cycle 0: instr=0, valid=0; cycle 1: instr=24080001, pc=40000000, instr_count=0.
REQ-035 Free-running sequential fetch -> pc steps 40000000, 40000004, 40000008; instr_old lags instr by one; instr_count=2 at the third instruction.
REQ-036 pcsel=01, branch_target=40000100 at pc=40000008 -> next cycle pc=40000100 and the instruction at 4000000C is never presented.
REQ-037 J with index 0000040 at pc=40000010 (pcsel=11) -> next pc=40000100; JR with pcsel=00, reg_target=40000203 -> imem_addr=40000200.
REQ-038 stall=1 for 2 cycles together with pcsel=01 -> pc, instr, instr_old and instr_count are frozen and the branch is ignored; the first cycle after stall drops acts on the current pcsel.
REQ-039 instr_count forced near 32'hFFFF_FFFF, then 2 advances -> 0, then 1; rst asserted mid-stall -> REQ-029/030 sequence.
